// File: rtl/sar_caparray_ctrl_if.sv
// Bus between the SAR sequencer and the caparray/comparator side.
// Optional differential bus: define CAPARRAY_BOTPLATE_D_EN to add cap_botplate_d.
interface sar_caparray_ctrl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic             abort;
    logic             comp_in;
    logic             sample;
    logic [WIDTH-1:0] cap_botplate;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef CAPARRAY_BOTPLATE_D_EN
    logic [WIDTH-1:0] cap_botplate_d;

    modport master (
        input  start, abort, comp_in,
        output sample, cap_botplate, busy, done, result, cap_botplate_d
    );
    modport slave (
        output start, abort, comp_in,
        input  sample, cap_botplate, busy, done, result, cap_botplate_d
    );
`else
    modport master (
        input  start, abort, comp_in,
        output sample, cap_botplate, busy, done, result
    );
    modport slave (
        output start, abort, comp_in,
        input  sample, cap_botplate, busy, done, result
    );
`endif
endinterface

// File: rtl/sar_caparray_ctrl.sv
// SAR sequencer driving the caparray bottom plates and resolving a WIDTH-bit code
// from the top-plate comparator. Track phase of SAMPLE_CYC cycles, then one trial per
// bit held SETTLE_CYC cycles, MSB first. Abort returns to idle without a result.
// Optional feature macro: CAPARRAY_BOTPLATE_D_EN (complementary bottom-plate bus).
module sar_caparray_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SAMPLE_CYC = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    sar_caparray_ctrl_if.master bus
);

    localparam int unsigned KW      = $clog2(WIDTH);
    localparam int unsigned CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] SampleLast = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYC - 1);
    localparam logic [KW-1:0] KMsb       = KW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StSample, StConv, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] code_q, code_d;      // decided bits above k; final code after DONE
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] k_onehot;
    logic [WIDTH-1:0] cap_drive;

    assign k_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;

`ifdef CAPARRAY_BOTPLATE_D_EN
    // Marks that code_q holds a completed conversion, so idle drives its complement.
    logic cplt_q, cplt_d;
`endif

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
`ifdef CAPARRAY_BOTPLATE_D_EN
            cplt_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            result_q <= result_d;
`ifdef CAPARRAY_BOTPLATE_D_EN
            cplt_q   <= cplt_d;
`endif
        end
    end

    // Next-state: phase timing, bit trials and abort handling.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        result_d = result_q;
`ifdef CAPARRAY_BOTPLATE_D_EN
        cplt_d   = cplt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Abort beats a simultaneous start.
                if (bus.start && !bus.abort) begin
                    state_d = StSample;
                    cnt_d   = '0;
                    code_d  = '0;
`ifdef CAPARRAY_BOTPLATE_D_EN
                    cplt_d  = 1'b0;
`endif
                end
            end
            StSample: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    code_d  = '0;
                end else if (cnt_q == SampleLast) begin
                    state_d = StConv;
                    cnt_d   = '0;
                    k_d     = KMsb;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StConv: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    code_d  = '0;
                end else if (cnt_q == SettleLast) begin
                    cnt_d = '0;
                    // comp_in=1 means the trial overshot: drop bit k.
                    if (!bus.comp_in) begin
                        code_d = code_q | k_onehot;
                    end
                    if (k_q == '0) begin
                        state_d  = StDone;
                        result_d = code_d;
`ifdef CAPARRAY_BOTPLATE_D_EN
                        cplt_d   = 1'b1;
`endif
                    end else begin
                        k_d = k_q - KW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bottom-plate drive decoded from phase.
    always_comb begin
        cap_drive = '0;
        unique case (state_q)
            StIdle:   cap_drive = code_q;
            StSample: cap_drive = '0;
            StConv:   cap_drive = code_q | k_onehot;
            StDone:   cap_drive = code_q;
            default:  cap_drive = '0;
        endcase
    end

    assign bus.sample       = (state_q == StSample);
    assign bus.busy         = (state_q == StSample) || (state_q == StConv);
    assign bus.done         = (state_q == StDone);
    assign bus.result       = result_q;
    assign bus.cap_botplate = cap_drive;

`ifdef CAPARRAY_BOTPLATE_D_EN
    // Complement is live only while a trial or a completed code is on the plates.
    always_comb begin
        bus.cap_botplate_d = '0;
        unique case (state_q)
            StIdle:   bus.cap_botplate_d = cplt_q ? ~cap_drive : '0;
            StSample: bus.cap_botplate_d = '0;
            StConv:   bus.cap_botplate_d = ~cap_drive;
            StDone:   bus.cap_botplate_d = ~cap_drive;
            default:  bus.cap_botplate_d = '0;
        endcase
    end
`endif

endmodule
